branch_ctx_decoder: RTL and testbench

Multi-context, parametrised successor to the CGRA branch/merge configuration decoder. It stores N_CTX complete array configurations, written one PE word at a time. On a handshaked context-switch request it decodes the selected context into registered per-PE branch flags, merge flags and branch-network select fields for the branch network. It sits between the configuration loader and the branch interconnect, and lets the next context be preloaded while the current one executes.

---
 rtl/branch_ctx_decoder.sv | 154 +++++++++++++++
 tb/tb_branch_ctx_decoder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctx_decoder.sv
// Multi-context CGRA branch/merge configuration decoder with handshaked context switching.
// Latency: outputs 2 cycles after accepting a loaded context; sw_ready stays low from accept until the decode completes.
module branch_ctx_decoder #(
    parameter int N_PE     = 16,
    parameter int CONF_W   = 22,
    parameter int OP_LSB   = 0,
    parameter int OP_W     = 4,
    parameter int NET_LSB  = 8,
    parameter int NET_W    = 4,
    parameter int N_CTX    = 4,
    parameter int OP_BEQ   = 11,
    parameter int OP_BNE   = 12,
    parameter int OP_MERGE = 15,
    localparam int CW = (N_CTX > 1) ? $clog2(N_CTX) : 1,
    localparam int PW = (N_PE > 1) ? $clog2(N_PE) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [CW-1:0]          wr_ctx,
    input  logic [PW-1:0]          wr_pe,
    input  logic [CONF_W-1:0]      wr_data,
    input  logic                   clr_en,
    input  logic [CW-1:0]          clr_ctx,
    output logic [N_CTX-1:0]       ctx_loaded,
    input  logic                   sw_valid,
    input  logic [CW-1:0]          sw_ctx,
    output logic                   sw_ready,
    output logic                   sw_err,
    output logic [N_PE-1:0]        branch_set,
    output logic [N_PE-1:0]        merge_set,
    output logic [N_PE*NET_W-1:0]  branch_net_conf,
    output logic [CW-1:0]          out_ctx,
    output logic                   out_valid
);

    localparam logic [CW:0]     CTX_LIM  = (CW+1)'(N_CTX);
    localparam logic [PW:0]     PE_LIM   = (PW+1)'(N_PE);
    localparam logic [OP_W-1:0] OP_BEQ_V = OP_W'(OP_BEQ);
    localparam logic [OP_W-1:0] OP_BNE_V = OP_W'(OP_BNE);
    localparam logic [OP_W-1:0] OP_MRG_V = OP_W'(OP_MERGE);

    typedef enum logic [1:0] {IDLE, WAIT_LOAD, DECODE} state_t;

    state_t                state, state_nxt;
    logic [CONF_W-1:0]     mem      [N_CTX][N_PE];
    logic [N_PE-1:0]       mask     [N_CTX];
    logic [N_PE-1:0]       mask_nxt [N_CTX];
    logic [CW-1:0]         tgt;
    logic                  wr_ok;
    logic                  sw_acc;
    logic                  sw_in_range;
    logic [N_PE-1:0]       br_d;
    logic [N_PE-1:0]       mg_d;
    logic [N_PE*NET_W-1:0] net_d;

    assign wr_ok       = wr_en && ({1'b0, wr_ctx} < CTX_LIM) && ({1'b0, wr_pe} < PE_LIM);
    assign sw_ready    = (state == IDLE);
    assign sw_acc      = sw_valid && sw_ready;
    assign sw_in_range = ({1'b0, sw_ctx} < CTX_LIM);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ctx][wr_pe] <= wr_data;
        end
    end

    // Clear is applied before the write, so a same-cycle pair leaves only the written bit.
    always_comb begin
        for (int c = 0; c < N_CTX; c++) begin
            mask_nxt[c] = mask[c];
            if (clr_en && clr_ctx == CW'(c)) begin
                mask_nxt[c] = '0;
            end
            for (int p = 0; p < N_PE; p++) begin
                if (wr_ok && wr_ctx == CW'(c) && wr_pe == PW'(p)) begin
                    mask_nxt[c][p] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctx_loaded <= '0;
            for (int c = 0; c < N_CTX; c++) begin
                mask[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CTX; c++) begin
                mask[c]       <= mask_nxt[c];
                ctx_loaded[c] <= &mask_nxt[c];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sw_acc && sw_in_range) begin
                    state_nxt = ctx_loaded[sw_ctx] ? DECODE : WAIT_LOAD;
                end
            end
            WAIT_LOAD: begin
                if (ctx_loaded[tgt]) begin
                    state_nxt = DECODE;
                end
            end
            DECODE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        br_d  = '0;
        mg_d  = '0;
        net_d = '0;
        for (int i = 0; i < N_PE; i++) begin
            br_d[i] = (mem[tgt][i][OP_LSB +: OP_W] == OP_BEQ_V) ||
                      (mem[tgt][i][OP_LSB +: OP_W] == OP_BNE_V);
            mg_d[i] = (mem[tgt][i][OP_LSB +: OP_W] == OP_MRG_V);
            net_d[i*NET_W +: NET_W] = mem[tgt][i][NET_LSB +: NET_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            tgt             <= '0;
            sw_err          <= 1'b0;
            out_valid       <= 1'b0;
            out_ctx         <= '0;
            branch_set      <= '0;
            merge_set       <= '0;
            branch_net_conf <= '0;
        end else begin
            state  <= state_nxt;
            sw_err <= sw_acc && !sw_in_range;
            if (sw_acc && sw_in_range) begin
                tgt       <= sw_ctx;
                out_valid <= 1'b0;
            end
            if (state == DECODE) begin
                branch_set      <= br_d;
                merge_set       <= mg_d;
                branch_net_conf <= net_d;
                out_ctx         <= tgt;
                out_valid       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_ctx_decoder.sv
// Directed checks on the default build plus N_CTX=3 error path and an N_PE=8/N_CTX=2 random sweep.
module tb_branch_ctx_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    int checks = 0;
    int failures = 0;

    // Instance A: N_PE=16, N_CTX=4
    logic wr_en_a, clr_en_a, sw_valid_a, sw_ready_a, sw_err_a, out_valid_a;
    logic [1:0] wr_ctx_a, clr_ctx_a, sw_ctx_a, out_ctx_a;
    logic [3:0] wr_pe_a, ctx_loaded_a;
    logic [21:0] wr_data_a;
    logic [15:0] branch_a, merge_a;
    logic [63:0] net_a;
    // Instance B: N_PE=8, N_CTX=2
    logic wr_en_b, clr_en_b, sw_valid_b, sw_ready_b, sw_err_b, out_valid_b;
    logic [0:0] wr_ctx_b, clr_ctx_b, sw_ctx_b, out_ctx_b;
    logic [2:0] wr_pe_b;
    logic [1:0] ctx_loaded_b;
    logic [21:0] wr_data_b;
    logic [7:0] branch_b, merge_b;
    logic [31:0] net_b;
    // Instance C: N_PE=4, N_CTX=3
    logic wr_en_c, clr_en_c, sw_valid_c, sw_ready_c, sw_err_c, out_valid_c;
    logic [1:0] wr_ctx_c, clr_ctx_c, sw_ctx_c, out_ctx_c, wr_pe_c;
    logic [2:0] ctx_loaded_c;
    logic [21:0] wr_data_c;
    logic [3:0] branch_c, merge_c;
    logic [15:0] net_c;

    branch_ctx_decoder #(.N_PE(16), .N_CTX(4)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_ctx(wr_ctx_a), .wr_pe(wr_pe_a),
        .wr_data(wr_data_a), .clr_en(clr_en_a), .clr_ctx(clr_ctx_a), .ctx_loaded(ctx_loaded_a),
        .sw_valid(sw_valid_a), .sw_ctx(sw_ctx_a), .sw_ready(sw_ready_a), .sw_err(sw_err_a),
        .branch_set(branch_a), .merge_set(merge_a), .branch_net_conf(net_a),
        .out_ctx(out_ctx_a), .out_valid(out_valid_a));

    branch_ctx_decoder #(.N_PE(8), .N_CTX(2), .CONF_W(22)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_ctx(wr_ctx_b), .wr_pe(wr_pe_b),
        .wr_data(wr_data_b), .clr_en(clr_en_b), .clr_ctx(clr_ctx_b), .ctx_loaded(ctx_loaded_b),
        .sw_valid(sw_valid_b), .sw_ctx(sw_ctx_b), .sw_ready(sw_ready_b), .sw_err(sw_err_b),
        .branch_set(branch_b), .merge_set(merge_b), .branch_net_conf(net_b),
        .out_ctx(out_ctx_b), .out_valid(out_valid_b));

    branch_ctx_decoder #(.N_PE(4), .N_CTX(3)) dut_c (
        .clk(clk), .rst(rst), .wr_en(wr_en_c), .wr_ctx(wr_ctx_c), .wr_pe(wr_pe_c),
        .wr_data(wr_data_c), .clr_en(clr_en_c), .clr_ctx(clr_ctx_c), .ctx_loaded(ctx_loaded_c),
        .sw_valid(sw_valid_c), .sw_ctx(sw_ctx_c), .sw_ready(sw_ready_c), .sw_err(sw_err_c),
        .branch_set(branch_c), .merge_set(merge_c), .branch_net_conf(net_c),
        .out_ctx(out_ctx_c), .out_valid(out_valid_c));

    // Reference storage: words as written, and per-context sets of written PEs.
    logic [21:0] mem_a [4][16];
    logic [21:0] mem_b [2][8];
    bit   [7:0]  mask_b [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word with the given opcode and net field; every other bit is random filler.
    function automatic logic [21:0] mkw(input int op, input int net);
        logic [21:0] w;
        w = 22'($urandom);
        w[3:0] = 4'(op);
        w[11:8] = 4'(net);
        return w;
    endfunction

    task automatic exp_a(input int c, output logic [63:0] br, output logic [63:0] mg, output logic [63:0] nt);
        int w, op, nf;
        br = '0; mg = '0; nt = '0;
        for (int p = 0; p < 16; p++) begin
            w = int'(mem_a[c][p]);
            op = w % 16;
            nf = (w / 256) % 16;
            if (op == 11 || op == 12) br[p] = 1'b1;
            if (op == 15) mg[p] = 1'b1;
            nt = nt | (64'(nf) << (4 * p));
        end
    endtask

    task automatic exp_b(input int c, output logic [7:0] br, output logic [7:0] mg, output logic [31:0] nt);
        int w, op, nf;
        br = '0; mg = '0; nt = '0;
        for (int p = 0; p < 8; p++) begin
            w = int'(mem_b[c][p]);
            op = w % 16;
            nf = (w / 256) % 16;
            if (op == 11 || op == 12) br[p] = 1'b1;
            if (op == 15) mg[p] = 1'b1;
            nt = nt | (32'(nf) << (4 * p));
        end
    endtask

    task automatic wr_a(input int c, input int p, input logic [21:0] d);
        wr_en_a = 1'b1; wr_ctx_a = 2'(c); wr_pe_a = 4'(p); wr_data_a = d;
        mem_a[c][p] = d;
        tick();
        wr_en_a = 1'b0;
    endtask

    task automatic sw_a(input int c);
        chk("a_sw_ready_before_accept", 64'(sw_ready_a), 64'd1);
        sw_valid_a = 1'b1; sw_ctx_a = 2'(c);
        tick();
        sw_valid_a = 1'b0;
    endtask

    task automatic wr_b(input int c, input int p, input logic [21:0] d);
        wr_en_b = 1'b1; wr_ctx_b = 1'(c); wr_pe_b = 3'(p); wr_data_b = d;
        mem_b[c][p] = d;
        mask_b[c][p] = 1'b1;
        tick();
        wr_en_b = 1'b0;
    endtask

    initial begin
        logic [63:0] ea_br, ea_mg, ea_nt;
        logic [7:0]  eb_br, eb_mg;
        logic [31:0] eb_nt;
        int          eb_oc, eb_ov, r, t, wc, wp, cc;
        bit          do_wr, do_clr;

        rst = 1'b1;
        wr_en_a = 0; wr_ctx_a = 0; wr_pe_a = 0; wr_data_a = 0; clr_en_a = 0; clr_ctx_a = 0; sw_valid_a = 0; sw_ctx_a = 0;
        wr_en_b = 0; wr_ctx_b = 0; wr_pe_b = 0; wr_data_b = 0; clr_en_b = 0; clr_ctx_b = 0; sw_valid_b = 0; sw_ctx_b = 0;
        wr_en_c = 0; wr_ctx_c = 0; wr_pe_c = 0; wr_data_c = 0; clr_en_c = 0; clr_ctx_c = 0; sw_valid_c = 0; sw_ctx_c = 0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_branch", 64'(branch_a), 64'd0);
        chk("rst_merge", 64'(merge_a), 64'd0);
        chk("rst_net", net_a, 64'd0);
        chk("rst_out_ctx", 64'(out_ctx_a), 64'd0);
        chk("rst_out_valid", 64'(out_valid_a), 64'd0);
        chk("rst_sw_err", 64'(sw_err_a), 64'd0);
        chk("rst_ctx_loaded", 64'(ctx_loaded_a), 64'd0);
        chk("rst_sw_ready", 64'(sw_ready_a), 64'd1);

        // Context 0: PE0 BEQ, PE1 BNE, PE2 MERGE, PE3 net A.
        for (int p = 0; p < 16; p++) begin
            if (p == 15) chk("ctx0_not_loaded_yet", 64'(ctx_loaded_a), 64'd0);
            wr_a(0, p, mkw(p == 0 ? 11 : p == 1 ? 12 : p == 2 ? 15 : 0, p == 3 ? 10 : 0));
        end
        chk("ctx0_loaded", 64'(ctx_loaded_a), 64'b0001);

        sw_a(0);
        chk("sw0_t1_ready", 64'(sw_ready_a), 64'd0);
        chk("sw0_t1_valid", 64'(out_valid_a), 64'd0);
        tick();
        chk("sw0_branch", 64'(branch_a), 64'h0003);
        chk("sw0_merge", 64'(merge_a), 64'h0004);
        chk("sw0_net", net_a, 64'hA000);
        chk("sw0_valid", 64'(out_valid_a), 64'd1);
        chk("sw0_out_ctx", 64'(out_ctx_a), 64'd0);
        chk("sw0_ready_again", 64'(sw_ready_a), 64'd1);

        // Rewriting the displayed context must not disturb the outputs.
        wr_a(0, 0, mkw(15, 0));
        tick();
        chk("rewrite_disp_branch", 64'(branch_a), 64'h0003);
        chk("rewrite_disp_merge", 64'(merge_a), 64'h0004);

        // Context 1 with one word missing: waits, holding the old outputs.
        for (int p = 0; p < 15; p++) wr_a(1, p, 22'($urandom));
        chk("ctx1_partial_not_loaded", 64'(ctx_loaded_a), 64'b0001);
        sw_a(1);
        chk("wait_ready", 64'(sw_ready_a), 64'd0);
        chk("wait_valid", 64'(out_valid_a), 64'd0);
        chk("wait_branch_held", 64'(branch_a), 64'h0003);
        tick(); tick(); tick();
        chk("wait_ready_still", 64'(sw_ready_a), 64'd0);
        chk("wait_merge_held", 64'(merge_a), 64'h0004);
        wr_a(1, 15, mkw(12, 5));
        chk("w1_loaded", 64'(ctx_loaded_a), 64'b0011);
        chk("w1_valid", 64'(out_valid_a), 64'd0);
        tick();
        chk("w2_valid", 64'(out_valid_a), 64'd0);
        tick();
        exp_a(1, ea_br, ea_mg, ea_nt);
        chk("w3_branch", 64'(branch_a), ea_br);
        chk("w3_merge", 64'(merge_a), ea_mg);
        chk("w3_net", net_a, ea_nt);
        chk("w3_valid", 64'(out_valid_a), 64'd1);
        chk("w3_out_ctx", 64'(out_ctx_a), 64'd1);

        // Back to ctx 0: acceptance-cycle write is seen, decode-cycle write is not.
        chk("sw0b_ready", 64'(sw_ready_a), 64'd1);
        sw_valid_a = 1'b1; sw_ctx_a = 2'd0;
        wr_en_a = 1'b1; wr_ctx_a = 2'd0; wr_pe_a = 4'd4; wr_data_a = mkw(11, 0);
        tick();
        sw_valid_a = 1'b0;
        wr_pe_a = 4'd5; wr_data_a = mkw(11, 0);
        tick();
        wr_en_a = 1'b0;
        chk("sw0b_branch", 64'(branch_a), 64'h0012);
        chk("sw0b_merge", 64'(merge_a), 64'h0005);
        chk("sw0b_net", net_a, 64'hA000);
        chk("sw0b_valid", 64'(out_valid_a), 64'd1);

        // Same-cycle clear and write on a fully loaded ctx 2 leaves only PE5 set.
        for (int p = 0; p < 16; p++) wr_a(2, p, 22'($urandom));
        chk("ctx2_loaded", 64'(ctx_loaded_a), 64'b0111);
        clr_en_a = 1'b1; clr_ctx_a = 2'd2;
        wr_a(2, 5, 22'($urandom));
        clr_en_a = 1'b0;
        chk("clrwr_loaded", 64'(ctx_loaded_a), 64'b0011);
        for (int p = 0; p < 16; p++) begin
            if (p == 15) chk("clrwr_before_last", 64'(ctx_loaded_a), 64'b0011);
            if (p != 5) wr_a(2, p, 22'($urandom));
        end
        chk("clrwr_completed", 64'(ctx_loaded_a), 64'b0111);
        clr_en_a = 1'b1; clr_ctx_a = 2'd0;
        tick();
        clr_en_a = 1'b0;
        chk("clr_disp_loaded", 64'(ctx_loaded_a), 64'b0110);
        chk("clr_disp_branch", 64'(branch_a), 64'h0012);
        chk("clr_disp_valid", 64'(out_valid_a), 64'd1);

        // N_CTX=3: ctx 3 is representable but out of range.
        for (int p = 0; p < 4; p++) begin
            wr_en_c = 1'b1; wr_ctx_c = 2'd2; wr_pe_c = 2'(p);
            wr_data_c = mkw(p == 0 ? 11 : p == 1 ? 15 : p == 3 ? 12 : 0, p + 1);
            tick();
        end
        wr_ctx_c = 2'd3; wr_pe_c = 2'd0; wr_data_c = mkw(11, 0);
        tick();
        wr_en_c = 1'b0;
        chk("c_loaded", 64'(ctx_loaded_c), 64'b100);
        sw_valid_c = 1'b1; sw_ctx_c = 2'd2;
        tick();
        sw_valid_c = 1'b0;
        tick();
        chk("c_branch", 64'(branch_c), 64'b1001);
        chk("c_merge", 64'(merge_c), 64'b0010);
        chk("c_net", 64'(net_c), 64'h4321);
        chk("c_out_ctx", 64'(out_ctx_c), 64'd2);
        chk("c_ready", 64'(sw_ready_c), 64'd1);
        sw_valid_c = 1'b1; sw_ctx_c = 2'd3;
        tick();
        sw_valid_c = 1'b0;
        chk("c_err_pulse", 64'(sw_err_c), 64'd1);
        chk("c_err_ready", 64'(sw_ready_c), 64'd1);
        chk("c_err_valid", 64'(out_valid_c), 64'd1);
        chk("c_err_branch", 64'(branch_c), 64'b1001);
        chk("c_err_out_ctx", 64'(out_ctx_c), 64'd2);
        tick();
        chk("c_err_cleared", 64'(sw_err_c), 64'd0);

        // Reset while waiting on the never-loaded ctx 3.
        sw_a(3);
        chk("pre_rst_wait", 64'(sw_ready_a), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_branch", 64'(branch_a), 64'd0);
        chk("midrst_merge", 64'(merge_a), 64'd0);
        chk("midrst_net", net_a, 64'd0);
        chk("midrst_valid", 64'(out_valid_a), 64'd0);
        chk("midrst_loaded", 64'(ctx_loaded_a), 64'd0);
        chk("midrst_ready", 64'(sw_ready_a), 64'd1);
        tick(); tick(); tick();
        chk("midrst_no_pending", 64'(out_valid_a), 64'd0);

        // Random loads, clears and switches on the N_PE=8, N_CTX=2 build.
        mask_b[0] = '0; mask_b[1] = '0;
        eb_br = '0; eb_mg = '0; eb_nt = '0; eb_oc = 0; eb_ov = 0;
        for (int it = 0; it < 1000; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7) begin
                do_wr  = (r < 6);
                do_clr = (r == 6) || ($urandom_range(0, 7) == 0);
                wc = int'($urandom_range(0, 1)); wp = int'($urandom_range(0, 7)); cc = int'($urandom_range(0, 1));
                wr_en_b = do_wr; wr_ctx_b = 1'(wc); wr_pe_b = 3'(wp); wr_data_b = 22'($urandom);
                clr_en_b = do_clr; clr_ctx_b = 1'(cc);
                if (do_clr) mask_b[cc] = '0;
                if (do_wr) begin
                    mem_b[wc][wp] = wr_data_b;
                    mask_b[wc][wp] = 1'b1;
                end
                tick();
                wr_en_b = 1'b0; clr_en_b = 1'b0;
                chk("b_loaded", 64'(ctx_loaded_b), {62'd0, mask_b[1] == 8'hFF, mask_b[0] == 8'hFF});
                chk("b_hold_branch", 64'(branch_b), 64'(eb_br));
                chk("b_hold_net", 64'(net_b), 64'(eb_nt));
                chk("b_hold_valid", 64'(out_valid_b), 64'(eb_ov));
            end else begin
                t = int'($urandom_range(0, 1));
                chk("b_sw_ready", 64'(sw_ready_b), 64'd1);
                sw_valid_b = 1'b1; sw_ctx_b = 1'(t);
                tick();
                sw_valid_b = 1'b0;
                chk("b_t1_ready", 64'(sw_ready_b), 64'd0);
                chk("b_t1_valid", 64'(out_valid_b), 64'd0);
                if (mask_b[t] != 8'hFF) begin
                    for (int p = 0; p < 8; p++) begin
                        if (!mask_b[t][p]) begin
                            wr_b(t, p, 22'($urandom));
                            chk("b_wait_ready", 64'(sw_ready_b), 64'd0);
                        end
                    end
                    tick();
                    chk("b_w2_valid", 64'(out_valid_b), 64'd0);
                end
                tick();
                exp_b(t, eb_br, eb_mg, eb_nt);
                eb_oc = t; eb_ov = 1;
                chk("b_branch", 64'(branch_b), 64'(eb_br));
                chk("b_merge", 64'(merge_b), 64'(eb_mg));
                chk("b_net", 64'(net_b), 64'(eb_nt));
                chk("b_out_ctx", 64'(out_ctx_b), 64'(eb_oc));
                chk("b_valid", 64'(out_valid_b), 64'd1);
                chk("b_sw_err", 64'(sw_err_b), 64'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
